segscan_4dig: RTL and testbench



---
 rtl/segscan_4dig.sv | 137 +++++++++++++
 tb/tb_segscan_4dig.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/segscan_4dig.sv
// Multiplexed 4-digit seven-segment scanner with a built-in hex decoder.
// New values wait in a shadow register and go live only at a frame boundary.
module segscan_4dig #(
  parameter int SCAN_DIV  = 12500,
  parameter int BLANK_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_i,
  input  logic [3:0]  dp_i,
  input  logic        load_i,
  input  logic        lz_blank_i,
  output logic [7:0]  seg_o,
  output logic [3:0]  dig_o,
  output logic        frame_o
);

  localparam int PH_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SCAN_DIV - 1);
  localparam logic [PH_W-1:0] PH_SHOW = PH_W'(BLANK_CYC);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } slot_state_t;

  logic [PH_W-1:0] ph, ph_next;
  logic [1:0]      idx, idx_next;
  slot_state_t     slot_state;

  logic [15:0] active_val, shadow_val;
  logic [3:0]  active_dp, shadow_dp;
  logic        pending, pending_next;
  logic        swap;

  logic [3:0]  nib;
  logic [15:0] upper_val;
  logic        lz_hit;
  logic [7:0]  seg_next;
  logic [3:0]  dig_next;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b011_1111;
      4'h1:    s = 7'b000_0110;
      4'h2:    s = 7'b101_1011;
      4'h3:    s = 7'b100_1111;
      4'h4:    s = 7'b110_0110;
      4'h5:    s = 7'b110_1101;
      4'h6:    s = 7'b111_1101;
      4'h7:    s = 7'b000_0111;
      4'h8:    s = 7'b111_1111;
      4'h9:    s = 7'b110_1111;
      4'hA:    s = 7'b111_0111;
      4'hB:    s = 7'b111_1100;
      4'hC:    s = 7'b011_1001;
      4'hD:    s = 7'b101_1110;
      4'hE:    s = 7'b111_1001;
      default: s = 7'b111_0001;
    endcase
    return s;
  endfunction

  // Slot state is a pure decode of the phase counter; ph is the state register.
  always_comb begin
    ph_next      = ph + 1'b1;
    idx_next     = idx;
    pending_next = pending;
    swap         = 1'b0;
    slot_state   = (ph < PH_SHOW) ? ST_BLANK : ST_SHOW;

    if (ph == PH_LAST) begin
      ph_next  = '0;
      idx_next = idx + 2'd1;
      swap     = (idx == 2'd3) && pending;
    end

    // A load on the swap cycle re-arms pending for the following frame.
    if (load_i) begin
      pending_next = 1'b1;
    end else if (swap) begin
      pending_next = 1'b0;
    end
  end

  // Leading zeros: the current nibble and every nibble above it are zero.
  always_comb begin
    nib       = active_val[{idx, 2'b00} +: 4];
    upper_val = active_val >> {idx, 2'b00};
    lz_hit    = lz_blank_i && (idx != 2'd0) && (upper_val == 16'h0000);

    seg_next = 8'h00;
    dig_next = 4'b1111;
    case (slot_state)
      ST_SHOW: begin
        dig_next = ~(4'b0001 << idx);
        seg_next = {active_dp[idx], lz_hit ? 7'b000_0000 : hex_to_seg(nib)};
      end
      default: begin
        seg_next = 8'h00;
        dig_next = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph         <= '0;
      idx        <= 2'd0;
      active_val <= 16'h0000;
      active_dp  <= 4'h0;
      shadow_val <= 16'h0000;
      shadow_dp  <= 4'h0;
      pending    <= 1'b0;
      seg_o      <= 8'h00;
      dig_o      <= 4'b1111;
      frame_o    <= 1'b0;
    end else begin
      ph      <= ph_next;
      idx     <= idx_next;
      pending <= pending_next;
      seg_o   <= seg_next;
      dig_o   <= dig_next;
      frame_o <= swap;
      if (swap) begin
        active_val <= shadow_val;
        active_dp  <= shadow_dp;
      end
      if (load_i) begin
        shadow_val <= value_i;
        shadow_dp  <= dp_i;
      end
    end
  end

endmodule

// File: tb/tb_segscan_4dig.sv
// Directed bench for segscan_4dig with an 8-cycle slot and 2 blank cycles.
module tb_segscan_4dig;

  logic        clk;
  logic        rst;
  logic [15:0] value_i;
  logic [3:0]  dp_i;
  logic        load_i;
  logic        lz_blank_i;
  logic [7:0]  seg_o;
  logic [3:0]  dig_o;
  logic        frame_o;

  int n_cmp;
  int n_err;

  int          ld_at  [3];
  logic [15:0] ld_val [3];
  logic [3:0]  ld_dp  [3];

  segscan_4dig #(
    .SCAN_DIV (8),
    .BLANK_CYC(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value_i   (value_i),
    .dp_i      (dp_i),
    .load_i    (load_i),
    .lz_blank_i(lz_blank_i),
    .seg_o     (seg_o),
    .dig_o     (dig_o),
    .frame_o   (frame_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_loads();
    for (int k = 0; k < 3; k++) begin
      ld_at[k]  = -1;
      ld_val[k] = 16'h0000;
      ld_dp[k]  = 4'h0;
    end
  endtask

  // Checks n_cyc samples of a frame that starts right after a frame boundary.
  // segs packs the shown segment byte per digit, digit k at [8k+:8].
  task automatic run_frame(input string name, input logic [31:0] segs,
                           input bit exp_frame, input int n_cyc);
    for (int i = 0; i < n_cyc; i++) begin
      int s;
      int p;
      logic [3:0] e_dig;
      logic [7:0] e_seg;
      s = i / 8;
      p = i % 8;
      @(negedge clk);
      if (p < 2) begin
        e_dig = 4'b1111;
        e_seg = 8'h00;
      end else begin
        e_dig = ~(4'b0001 << s);
        e_seg = segs[8*s +: 8];
      end
      check_eq($sformatf("%s dig c%0d", name, i), {28'h0, dig_o}, {28'h0, e_dig});
      check_eq($sformatf("%s seg c%0d", name, i), {24'h0, seg_o}, {24'h0, e_seg});
      check_eq($sformatf("%s frame c%0d", name, i), {31'h0, frame_o},
               {31'h0, (exp_frame && i == 31)});
      load_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (ld_at[k] == i) begin
          load_i  = 1'b1;
          value_i = ld_val[k];
          dp_i    = ld_dp[k];
        end
      end
    end
    load_i = 1'b0;
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    value_i    = 16'h0000;
    dp_i       = 4'h0;
    load_i     = 1'b0;
    lz_blank_i = 1'b0;
    clear_loads();

    repeat (3) @(negedge clk);
    check_eq("reset dig", {28'h0, dig_o}, 32'hF);
    check_eq("reset seg", {24'h0, seg_o}, 32'h00);
    check_eq("reset frame", {31'h0, frame_o}, 32'h0);
    rst = 1'b0;

    // idle frame, all zeros
    run_frame("idle", 32'h3F3F3F3F, 1'b0, 32);

    // mid-frame load of 1234 stays hidden until the boundary
    clear_loads();
    ld_at[0] = 10; ld_val[0] = 16'h1234; ld_dp[0] = 4'h0;
    run_frame("ld1234", 32'h3F3F3F3F, 1'b1, 32);

    // 1234 shown; lz on has no effect; queue 0007 with DP on digit 2
    lz_blank_i = 1'b1;
    clear_loads();
    ld_at[0] = 10; ld_val[0] = 16'h0007; ld_dp[0] = 4'b0100;
    run_frame("show1234", 32'h065B4F66, 1'b1, 32);

    // 0007 with leading-zero blanking, DP survives on digit 2
    clear_loads();
    ld_at[0] = 10; ld_val[0] = 16'h0000; ld_dp[0] = 4'h0;
    run_frame("lz0007", 32'h00800007, 1'b1, 32);

    // all-zero value keeps digit 0; AAAA, F00D, then 5555 on the swap cycle
    clear_loads();
    ld_at[0] = 5;  ld_val[0] = 16'hAAAA; ld_dp[0] = 4'h0;
    ld_at[1] = 15; ld_val[1] = 16'hF00D; ld_dp[1] = 4'h0;
    ld_at[2] = 30; ld_val[2] = 16'h5555; ld_dp[2] = 4'h0;
    run_frame("lz0000", 32'h0000003F, 1'b1, 32);
    lz_blank_i = 1'b0;

    clear_loads();
    run_frame("showF00D", 32'h713F3F5E, 1'b1, 32);
    run_frame("show5555", 32'h6D6D6D6D, 1'b0, 32);

    // pending load then reset during SHOW of digit 2
    clear_loads();
    ld_at[0] = 5; ld_val[0] = 16'h9999; ld_dp[0] = 4'hF;
    run_frame("pre_rst", 32'h6D6D6D6D, 1'b0, 20);
    clear_loads();
    rst = 1'b1;
    #1;
    check_eq("async rst dig", {28'h0, dig_o}, 32'hF);
    check_eq("async rst seg", {24'h0, seg_o}, 32'h00);
    check_eq("async rst frame", {31'h0, frame_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_frame("post_rst", 32'h3F3F3F3F, 1'b0, 32);
    run_frame("post_rst2", 32'h3F3F3F3F, 1'b0, 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
